multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter XLEN, default 32, datapath/address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter TIMEOUT, default 16, max cycles from request acceptance to response before trap.
REQ-004 Parameter CNT_W, default 32, retire counter width.
REQ-005 One clock, clk_in; reset rst_in is asynchronous and active-high.
REQ-006 clk_in  in  1  system clock.
REQ-007 rst_in  in  1  async active-high reset.
REQ-008 imem_req_out  out  1 / imem_addr_out  out  XLEN / imem_ready_in  in  1 / imem_valid_in  in  1 / imem_data_in  in  32: instruction fetch port.
REQ-009 dmem_req_out  out  1 / dmem_we_out  out  1 / dmem_addr_out  out  XLEN / dmem_wdata_out  out  XLEN / dmem_ready_in  in  1 / dmem_valid_in  in  1 / dmem_rdata_in  in  XLEN: data port.
REQ-010 dec_mem_op_in  in  2  00 none, 01 load, 10 store, 11 illegal; dec_rd_we_in  in  1  writes rd; dec_illegal_in  in  1  undecodable instruction.
REQ-011 ex_next_pc_in, ex_addr_in, ex_result_in, rval2_in  in  XLEN  execute-stage results.
REQ-012 inst_out  out  32 latched instruction; pc_out  out  XLEN current PC.
REQ-013 rf_we_out  out  1 / rf_wd_out  out  XLEN: register-file write strobe/data.
REQ-014 state_out  out  3 current state; trap_out  out  1 sticky fault; retire_count_out  out  CNT_W retired instructions.

Function
REQ-015 States/encoding: FETCH=0, FETCH_WAIT=1, DECODE=2, EXECUTE=3, MEM=4, MEM_WAIT=5, WRITEBACK=6, TRAP=7.
REQ-016 Request handshake: req held high until sampled with ready high at a posedge (accept); address/data/we stable while req high; req drops the cycle after accept.
REQ-017 Response: valid sampled in the *_WAIT state only; valid in the accept cycle is ignored; earliest usable response is one cycle after accept.
REQ-018 FETCH: imem_req_out=1, imem_addr_out=pc_out; on accept -> FETCH_WAIT.
REQ-019 FETCH_WAIT: on imem_valid_in latch imem_data_in into inst_out -> DECODE.
REQ-020 DECODE: one cycle -> EXECUTE; dec_illegal_in=1 or dec_mem_op_in=11 -> TRAP.
REQ-021 EXECUTE: latch ex_result_in, ex_addr_in, rval2_in, ex_next_pc_in; mem_op 01/10 -> MEM, else -> WRITEBACK.
REQ-022 MEM: dmem_req_out=1, dmem_addr_out=latched addr, dmem_we_out=1 for store, dmem_wdata_out=latched rval2; on accept -> MEM_WAIT.
REQ-023 MEM_WAIT: on dmem_valid_in -> WRITEBACK; load latches dmem_rdata_in; store treats valid as write ack.
REQ-024 WRITEBACK: rf_we_out=dec_rd_we_in for exactly one cycle and never for stores; rf_wd_out=load data for loads else latched result; pc_out<=latched next PC; retire_count_out+1 (wraps mod 2^CNT_W) -> FETCH.
REQ-025 Latency with ready=1 and valid one cycle after accept: ALU/branch 5 cycles per instruction, load/store 7.
REQ-026 Timeout: counter clears on accept, increments each *_WAIT cycle without valid; reaching TIMEOUT -> TRAP.
REQ-027 Misalignment: pc_out[1:0]!=0 in FETCH, or latched addr[1:0]!=0 in EXECUTE with mem_op 01/10 -> TRAP, no request issued.
REQ-028 TRAP: trap_out=1, all req/we outputs 0, pc_out and retire count frozen; exit only by reset.
REQ-029 Outputs are registered or decoded from state only; no combinational path from *_ready_in/*_valid_in to outputs.

Reset
REQ-030 rst_in asserted at any time, including mid-handshake, immediately forces state FETCH, pc_out=RESET_PC, inst_out=0, rf_we_out=0, rf_wd_out=0, all req/we=0, trap_out=0, retire_count_out=0, timeout counter=0; late responses after reset are ignored.
REQ-031 First imem request issues the first posedge after rst_in deasserts.

Verification
REQ-032 Reset, inst 32'h0015_8593, result 5, rd_we=1, ready=1, valid +1 cycle -> rf_we_out one pulse with wd=5 at cycle 5, pc_out=4, retire=1.
REQ-033 Load addr 32'h100, rdata 32'hDEAD_BEEF, dmem_ready low 3 cycles -> req held 4 cycles, rf_wd_out=32'hDEAD_BEEF, 10 cycles total.
REQ-034 Store addr 32'h104, rval2 7 -> dmem_we_out=1, wdata=7, rf_we_out never asserted, retire+1.
REQ-035 imem_valid never returns with TIMEOUT=16 -> TRAP 16 cycles after accept, trap_out=1, outputs idle.
REQ-036 Load addr 32'h102 -> TRAP from EXECUTE, dmem_req_out never asserted.
REQ-037 rst_in pulse during MEM_WAIT then stale dmem_valid_in -> state FETCH, pc_out=RESET_PC, no register write.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: walks one instruction at a time through
// fetch, decode, execute, optional memory access and writeback. Both memory
// ports use a req/ready accept handshake followed by a valid response. A
// response timeout or a misaligned address parks the core in a sticky TRAP
// state that only reset can leave.
module multicycle_control #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              TIMEOUT  = 16,
    parameter int              CNT_W    = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    // instruction fetch port
    output logic             imem_req_out,
    output logic [XLEN-1:0]  imem_addr_out,
    input  logic             imem_ready_in,
    input  logic             imem_valid_in,
    input  logic [31:0]      imem_data_in,
    // data port
    output logic             dmem_req_out,
    output logic             dmem_we_out,
    output logic [XLEN-1:0]  dmem_addr_out,
    output logic [XLEN-1:0]  dmem_wdata_out,
    input  logic             dmem_ready_in,
    input  logic             dmem_valid_in,
    input  logic [XLEN-1:0]  dmem_rdata_in,
    // decoder information
    input  logic [1:0]       dec_mem_op_in,
    input  logic             dec_rd_we_in,
    input  logic             dec_illegal_in,
    // execute-stage results
    input  logic [XLEN-1:0]  ex_next_pc_in,
    input  logic [XLEN-1:0]  ex_addr_in,
    input  logic [XLEN-1:0]  ex_result_in,
    input  logic [XLEN-1:0]  rval2_in,
    // architectural / status outputs
    output logic [31:0]      inst_out,
    output logic [XLEN-1:0]  pc_out,
    output logic             rf_we_out,
    output logic [XLEN-1:0]  rf_wd_out,
    output logic [2:0]       state_out,
    output logic             trap_out,
    output logic [CNT_W-1:0] retire_count_out
);

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_DECODE     = 3'd2,
        S_EXECUTE    = 3'd3,
        S_MEM        = 3'd4,
        S_MEM_WAIT   = 3'd5,
        S_WRITEBACK  = 3'd6,
        S_TRAP       = 3'd7
    } state_t;

    localparam logic [1:0] MOP_NONE  = 2'b00;
    localparam logic [1:0] MOP_LOAD  = 2'b01;
    localparam logic [1:0] MOP_STORE = 2'b10;
    localparam logic [1:0] MOP_ILL   = 2'b11;

    // The wait counter only needs to reach TIMEOUT-1: the wait cycle that
    // would make it TIMEOUT moves to TRAP instead.
    localparam int              TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t             state_q,   state_d;
    logic [XLEN-1:0]    pc_q,      pc_d;
    logic [31:0]        inst_q,    inst_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;   // ALU result, replaced by load data
    logic [XLEN-1:0]    addr_q,    addr_d;
    logic [XLEN-1:0]    wdata_q,   wdata_d;
    logic [XLEN-1:0]    next_pc_q, next_pc_d;
    logic [1:0]         mem_op_q,  mem_op_d;
    logic               rd_we_q,   rd_we_d;
    logic [TMO_W-1:0]   tmo_q,     tmo_d;
    logic [CNT_W-1:0]   retire_q,  retire_d;

    logic               ex_is_mem;

    // State register and all latched datapath values; reset is asynchronous
    // so a reset in the middle of a handshake takes effect at once.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            wb_data_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            next_pc_q <= '0;
            mem_op_q  <= MOP_NONE;
            rd_we_q   <= 1'b0;
            tmo_q     <= '0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            wb_data_q <= wb_data_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            next_pc_q <= next_pc_d;
            mem_op_q  <= mem_op_d;
            rd_we_q   <= rd_we_d;
            tmo_q     <= tmo_d;
            retire_q  <= retire_d;
        end
    end

    // Next-state logic: sequencing, handshake accepts, response capture,
    // timeout and alignment checks.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        wb_data_d = wb_data_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        next_pc_d = next_pc_q;
        mem_op_d  = mem_op_q;
        rd_we_d   = rd_we_q;
        tmo_d     = tmo_q;
        retire_d  = retire_q;
        ex_is_mem = (dec_mem_op_in == MOP_LOAD) || (dec_mem_op_in == MOP_STORE);

        case (state_q)
            S_FETCH: begin
                // A misaligned PC never issues a request.
                if (pc_q[1:0] != 2'b00) begin
                    state_d = S_TRAP;
                end else if (imem_ready_in) begin
                    state_d = S_FETCH_WAIT;
                    tmo_d   = '0;
                end
            end
            S_FETCH_WAIT: begin
                if (imem_valid_in) begin
                    inst_d  = imem_data_in;
                    state_d = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DECODE: begin
                if (dec_illegal_in || (dec_mem_op_in == MOP_ILL)) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                wb_data_d = ex_result_in;
                addr_d    = ex_addr_in;
                wdata_d   = rval2_in;
                next_pc_d = ex_next_pc_in;
                mem_op_d  = dec_mem_op_in;
                rd_we_d   = dec_rd_we_in;
                if (ex_is_mem && (ex_addr_in[1:0] != 2'b00)) begin
                    state_d = S_TRAP;
                end else if (ex_is_mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                if (dmem_ready_in) begin
                    state_d = S_MEM_WAIT;
                    tmo_d   = '0;
                end
            end
            S_MEM_WAIT: begin
                // For a store the valid pulse is only the write acknowledge.
                if (dmem_valid_in) begin
                    if (mem_op_q == MOP_LOAD) begin
                        wb_data_d = dmem_rdata_in;
                    end
                    state_d = S_WRITEBACK;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WRITEBACK: begin
                pc_d     = next_pc_q;
                retire_d = retire_q + CNT_W'(1);
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // Outputs come from state and latched values only; the fetch request is
    // also held low while reset is asserted.
    assign imem_req_out     = (state_q == S_FETCH) && (pc_q[1:0] == 2'b00) && !rst_in;
    assign imem_addr_out    = pc_q;
    assign dmem_req_out     = (state_q == S_MEM);
    assign dmem_we_out      = (state_q == S_MEM) && (mem_op_q == MOP_STORE);
    assign dmem_addr_out    = addr_q;
    assign dmem_wdata_out   = wdata_q;
    assign inst_out         = inst_q;
    assign pc_out           = pc_q;
    assign rf_we_out        = (state_q == S_WRITEBACK) && rd_we_q && (mem_op_q != MOP_STORE);
    assign rf_wd_out        = wb_data_q;
    assign state_out        = state_q;
    assign trap_out         = (state_q == S_TRAP);
    assign retire_count_out = retire_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a schedule-level model builds the expected
// per-cycle outputs of each instruction from its handshake delays; one
// process compares them every cycle, and literal checks pin the model.
module tb_multicycle_control;

    localparam int          XLEN     = 32;
    localparam int          TIMEOUT  = 16;
    localparam int          CNT_W    = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        imem_req_out, imem_ready_in, imem_valid_in;
    logic [31:0] imem_addr_out, imem_data_in;
    logic        dmem_req_out, dmem_we_out, dmem_ready_in, dmem_valid_in;
    logic [31:0] dmem_addr_out, dmem_wdata_out, dmem_rdata_in;
    logic [1:0]  dec_mem_op_in;
    logic        dec_rd_we_in, dec_illegal_in;
    logic [31:0] ex_next_pc_in, ex_addr_in, ex_result_in, rval2_in;
    logic [31:0] inst_out, pc_out, rf_wd_out, retire_count_out;
    logic        rf_we_out, trap_out;
    logic [2:0]  state_out;

    multicycle_control #(
        .XLEN(XLEN), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .imem_ready_in(imem_ready_in), .imem_valid_in(imem_valid_in),
        .imem_data_in(imem_data_in),
        .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
        .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
        .dmem_ready_in(dmem_ready_in), .dmem_valid_in(dmem_valid_in),
        .dmem_rdata_in(dmem_rdata_in),
        .dec_mem_op_in(dec_mem_op_in), .dec_rd_we_in(dec_rd_we_in),
        .dec_illegal_in(dec_illegal_in),
        .ex_next_pc_in(ex_next_pc_in), .ex_addr_in(ex_addr_in),
        .ex_result_in(ex_result_in), .rval2_in(rval2_in),
        .inst_out(inst_out), .pc_out(pc_out),
        .rf_we_out(rf_we_out), .rf_wd_out(rf_wd_out),
        .state_out(state_out), .trap_out(trap_out),
        .retire_count_out(retire_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0]  st;
        logic        ireq;
        logic        dreq;
        logic        dwe;
        logic        rfwe;
        logic [31:0] rfwd;
        logic [31:0] pc;
        logic [31:0] ret;
        logic        trap;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] inst;
        bit          chk_inst;
    } exp_t;

    exp_t        expq[$];
    exp_t        ce;
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected record for one cycle spent in the given state.
    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e.st = st; e.ireq = 1'b0; e.dreq = 1'b0; e.dwe = 1'b0; e.rfwe = 1'b0;
        e.rfwd = '0; e.pc = m_pc; e.ret = m_ret; e.trap = (st == 3'd7);
        e.daddr = '0; e.dwdata = '0; e.inst = '0; e.chk_inst = 1'b0;
        return e;
    endfunction

    task automatic step(input exp_t e);
        expq.push_back(e);
        @(posedge clk_in);
        #1;
    endtask

    // Single compare process: one expected record per cycle, checked mid-cycle.
    always @(negedge clk_in) begin
        if (expq.size() > 0) begin
            ce = expq.pop_front();
            chk("state", state_out, ce.st);
            chk("imem_req", imem_req_out, ce.ireq);
            chk("dmem_req", dmem_req_out, ce.dreq);
            chk("dmem_we", dmem_we_out, ce.dwe);
            chk("rf_we", rf_we_out, ce.rfwe);
            chk("pc", pc_out, ce.pc);
            chk("retire", retire_count_out, ce.ret);
            chk("trap", trap_out, ce.trap);
            if (ce.ireq) chk("imem_addr", imem_addr_out, ce.pc);
            if (ce.dreq) begin
                chk("dmem_addr", dmem_addr_out, ce.daddr);
                chk("dmem_wdata", dmem_wdata_out, ce.dwdata);
            end
            if (ce.rfwe) chk("rf_wd", rf_wd_out, ce.rfwd);
            if (ce.chk_inst) chk("inst", inst_out, ce.inst);
            if (rf_we_out) pulses++;
        end
    end

    task automatic clear_inputs();
        imem_ready_in = 0; imem_valid_in = 0; imem_data_in = '0;
        dmem_ready_in = 0; dmem_valid_in = 0; dmem_rdata_in = '0;
        dec_mem_op_in = 2'b00; dec_rd_we_in = 0; dec_illegal_in = 0;
        ex_next_pc_in = '0; ex_addr_in = '0; ex_result_in = '0; rval2_in = '0;
    endtask

    // Holds reset for n cycles; leaves rst_in asserted for the caller to drop.
    task automatic do_reset(input int n);
        exp_t e;
        rst_in = 1'b1;
        clear_inputs();
        m_pc  = RESET_PC;
        m_ret = '0;
        for (int i = 0; i < n; i++) begin
            e = mk(3'd0);
            step(e);
        end
    endtask

    // One instruction. kind: 0 ALU, 1 load, 2 store. ir/dr = cycles ready is
    // held low, iv/dv = cycles from accept to valid. abort_mw >= 0 leaves
    // after that many MEM_WAIT cycles. cyc returns cycles to retirement.
    task automatic run_instr(input logic [31:0] inst, input int kind, input logic rd_we,
                             input logic [31:0] res, input logic [31:0] addr,
                             input logic [31:0] rv2, input logic [31:0] npc,
                             input logic [31:0] rdata, input int ir, input int iv,
                             input int dr, input int dv, input int abort_mw,
                             output int cyc);
        exp_t e;
        cyc = 0;
        dec_mem_op_in  = (kind == 1) ? 2'b01 : (kind == 2) ? 2'b10 : 2'b00;
        dec_rd_we_in   = rd_we;
        dec_illegal_in = 1'b0;
        ex_result_in   = res;
        ex_addr_in     = addr;
        rval2_in       = rv2;
        ex_next_pc_in  = npc;
        for (int c = 0; c <= ir; c++) begin
            imem_ready_in = (c == ir);
            imem_valid_in = (c == ir);   // valid during accept must be ignored
            imem_data_in  = 32'hBAD0_0000;
            e = mk(3'd0); e.ireq = 1'b1;
            step(e); cyc++;
        end
        imem_ready_in = 1'b0;
        for (int c = 1; c <= iv; c++) begin
            imem_valid_in = (c == iv);
            imem_data_in  = (c == iv) ? inst : 32'hBAD1_0000;
            e = mk(3'd1);
            step(e); cyc++;
        end
        imem_valid_in = 1'b0;
        imem_data_in  = 32'hBAD2_0000;
        e = mk(3'd2); e.chk_inst = 1'b1; e.inst = inst;
        step(e); cyc++;
        e = mk(3'd3); e.chk_inst = 1'b1; e.inst = inst;
        step(e); cyc++;
        if (kind != 0) begin
            for (int c = 0; c <= dr; c++) begin
                dmem_ready_in = (c == dr);
                dmem_valid_in = (c == dr);
                dmem_rdata_in = 32'hBAD3_0000;
                e = mk(3'd4); e.dreq = 1'b1; e.dwe = (kind == 2);
                e.daddr = addr; e.dwdata = rv2;
                step(e); cyc++;
            end
            dmem_ready_in = 1'b0;
            for (int c = 1; c <= dv; c++) begin
                if (abort_mw >= 0 && c > abort_mw) return;
                dmem_valid_in = (c == dv);
                dmem_rdata_in = (c == dv) ? rdata : 32'hBAD4_0000;
                e = mk(3'd5);
                step(e); cyc++;
            end
            dmem_valid_in = 1'b0;
        end
        e = mk(3'd6);
        e.rfwe = rd_we && (kind != 2);
        e.rfwd = (kind == 1) ? rdata : res;
        step(e); cyc++;
        m_pc  = npc;
        m_ret = m_ret + 1;
    endtask

    // Instruction that traps after DECODE (trap_at 2) or EXECUTE (trap_at 3).
    task automatic run_trap_instr(input logic [31:0] inst, input logic [1:0] op,
                                  input logic illegal, input logic [31:0] addr,
                                  input int trap_at);
        exp_t e;
        dec_mem_op_in = op; dec_illegal_in = illegal; dec_rd_we_in = 1'b1;
        ex_addr_in = addr; ex_result_in = 32'h55; rval2_in = 32'h66;
        ex_next_pc_in = m_pc + 4;
        imem_ready_in = 1'b1;
        e = mk(3'd0); e.ireq = 1'b1;
        step(e);
        imem_ready_in = 1'b0; imem_valid_in = 1'b1; imem_data_in = inst;
        e = mk(3'd1);
        step(e);
        imem_valid_in = 1'b0;
        e = mk(3'd2); e.chk_inst = 1'b1; e.inst = inst;
        step(e);
        if (trap_at == 3) begin
            e = mk(3'd3);
            step(e);
        end
        for (int i = 0; i < 4; i++) begin
            imem_ready_in = 1; imem_valid_in = 1; dmem_ready_in = 1; dmem_valid_in = 1;
            e = mk(3'd7);
            step(e);
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   p0;
        exp_t e;
        rst_in = 1'b1;
        clear_inputs();
        m_pc = RESET_PC; m_ret = '0;
        @(posedge clk_in); #1;

        // Reset state
        do_reset(2);
        chk("rst_state", state_out, 3'd0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_inst", inst_out, 32'h0);
        chk("rst_rf_wd", rf_wd_out, 32'h0);
        chk("rst_imem_req", imem_req_out, 1'b0);
        chk("rst_trap", trap_out, 1'b0);
        rst_in = 1'b0;

        // ALU instruction, minimum latency
        p0 = pulses;
        run_instr(32'h0015_8593, 0, 1'b1, 32'd5, 32'h0, 32'h0, 32'h4, 32'h0,
                  0, 1, 0, 0, -1, cyc);
        chk("alu_cycles", cyc, 5);
        chk("alu_pc", pc_out, 32'h4);
        chk("alu_retire", retire_count_out, 32'd1);
        chk("alu_pulses", pulses - p0, 1);

        // Load with dmem_ready low for three cycles
        run_instr(32'h1000_2083, 1, 1'b1, 32'h77, 32'h100, 32'h0, 32'h8, 32'hDEAD_BEEF,
                  0, 1, 3, 1, -1, cyc);
        chk("load_cycles", cyc, 10);
        chk("load_wd", rf_wd_out, 32'hDEAD_BEEF);
        chk("load_retire", retire_count_out, 32'd2);

        // Store with rd_we set by the decoder: still no register write
        p0 = pulses;
        run_instr(32'h0070_2223, 2, 1'b1, 32'h99, 32'h104, 32'd7, 32'hC, 32'h0,
                  0, 1, 0, 1, -1, cyc);
        chk("store_cycles", cyc, 7);
        chk("store_pulses", pulses - p0, 0);
        chk("store_retire", retire_count_out, 32'd3);

        // Slow fetch, no register write
        run_instr(32'h0000_0013, 0, 1'b0, 32'h1234, 32'h0, 32'h0, 32'h10, 32'h0,
                  2, 3, 0, 0, -1, cyc);
        // Load with a long response delay
        run_instr(32'h2000_2103, 1, 1'b1, 32'h0, 32'h200, 32'h0, 32'h14, 32'h0BAD_F00D,
                  0, 1, 1, 4, -1, cyc);

        // Reset during MEM_WAIT, then a stale response
        run_instr(32'h3000_2183, 1, 1'b1, 32'h0, 32'h300, 32'h0, 32'h18, 32'h1111_2222,
                  0, 1, 0, 10, 2, cyc);
        do_reset(1);
        chk("mid_rst_state", state_out, 3'd0);
        chk("mid_rst_pc", pc_out, 32'h0);
        rst_in = 1'b0;
        dmem_valid_in = 1'b1; dmem_rdata_in = 32'h5A5A_5A5A;
        p0 = pulses;
        run_instr(32'h0010_0093, 0, 1'b1, 32'd9, 32'h0, 32'h0, 32'h4, 32'h0,
                  0, 1, 0, 0, -1, cyc);
        chk("stale_pulses", pulses - p0, 1);
        chk("stale_retire", retire_count_out, 32'd1);
        chk("stale_wd", rf_wd_out, 32'd9);
        dmem_valid_in = 1'b0;

        // Fetch response never arrives
        do_reset(1); rst_in = 1'b0;
        imem_ready_in = 1'b1;
        e = mk(3'd0); e.ireq = 1'b1;
        step(e);
        imem_ready_in = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            e = mk(3'd1);
            step(e);
        end
        for (int i = 0; i < 3; i++) begin
            imem_valid_in = 1'b1; imem_ready_in = 1'b1;
            e = mk(3'd7);
            step(e);
        end
        chk("tmo_state", state_out, 3'd7);
        chk("tmo_trap", trap_out, 1'b1);
        chk("tmo_imem_req", imem_req_out, 1'b0);
        clear_inputs();

        // Misaligned load address
        do_reset(1); rst_in = 1'b0;
        run_trap_instr(32'h1020_2083, 2'b01, 1'b0, 32'h102, 3);
        chk("misal_trap", trap_out, 1'b1);
        chk("misal_dreq", dmem_req_out, 1'b0);
        chk("misal_retire", retire_count_out, 32'd0);

        // Illegal instruction, then mem_op 11
        do_reset(1); rst_in = 1'b0;
        run_trap_instr(32'hFFFF_FFFF, 2'b00, 1'b1, 32'h0, 2);
        do_reset(1); rst_in = 1'b0;
        run_trap_instr(32'hFFFF_FFFE, 2'b11, 1'b0, 32'h0, 2);
        chk("mop11_state", state_out, 3'd7);

        // Misaligned PC after a jump to 0x6
        do_reset(1); rst_in = 1'b0;
        run_instr(32'h0060_006F, 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h6, 32'h0,
                  0, 1, 0, 0, -1, cyc);
        imem_ready_in = 1'b1;
        e = mk(3'd0);
        step(e);
        for (int i = 0; i < 3; i++) begin
            e = mk(3'd7);
            step(e);
        end
        chk("pcmis_pc", pc_out, 32'h6);
        chk("pcmis_retire", retire_count_out, 32'd1);
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
